// File: rtl/stream_downsizer.sv
// stream_downsizer: splits DW_OUT*SCALE-bit words into DW_OUT beats, LSB or MSB slice first; optional STREAM_DOWNSIZER_SKID_EN.
// Latency: 1 cycle from input handshake to beat 0; one beat per cycle sustained across words.
// Backpressure: s_ready_o follows m_ready_i on the final beat, or comes from a flop when the skid word is enabled.
module stream_downsizer #(
    parameter int DW_OUT     = 8,
    parameter int SCALE      = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW_OUT*SCALE-1:0]  s_data_i,
    input  logic [$clog2(SCALE)-1:0] s_len_i,
    input  logic                     s_last_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    output logic [DW_OUT-1:0]        m_data_o,
    output logic                     m_last_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i
);
    localparam int IW    = $clog2(SCALE);
    localparam int DW_IN = DW_OUT * SCALE;
    localparam logic [IW-1:0] LIM_MAX = IW'(SCALE - 1);

    typedef enum logic {EMPTY, BUSY} state_t;

    state_t           r_state, w_state_nxt;
    logic [IW-1:0]    r_idx, w_idx_nxt;
    logic [IW-1:0]    r_lim, w_lim_nxt;
    logic [DW_IN-1:0] r_word, w_word_nxt;
    logic             r_last, w_last_nxt;
    logic             r_init;

    logic             w_empty, w_busy, w_final, w_rd, w_rd_final, w_wr;
    logic [IW-1:0]    w_in_lim, w_sel;
    logic             w_load;
    logic [DW_IN-1:0] w_ld_word;
    logic             w_ld_last;
    logic [IW-1:0]    w_ld_lim;

    assign w_empty    = (r_state == EMPTY);
    assign w_busy     = (r_state == BUSY) & ~rst;
    assign w_final    = (r_idx == r_lim);
    assign w_rd       = w_busy & m_ready_i;
    assign w_rd_final = w_rd & w_final;
    assign w_wr       = s_valid_i & s_ready_o;
    // Length only matters on the last word of a packet; oversize lengths clamp to a full word.
    assign w_in_lim   = !s_last_i ? LIM_MAX :
                        (int'(s_len_i) > SCALE - 1) ? LIM_MAX : s_len_i;

`ifdef STREAM_DOWNSIZER_SKID_EN
    logic             r_skid_vld;
    logic [DW_IN-1:0] r_skid_word;
    logic             r_skid_last;
    logic [IW-1:0]    r_skid_lim;

    assign s_ready_o = ~rst & ~r_init & ~r_skid_vld;
    assign w_load    = (w_empty | w_rd_final) & (r_skid_vld | w_wr);
    assign w_ld_word = r_skid_vld ? r_skid_word : s_data_i;
    assign w_ld_last = r_skid_vld ? r_skid_last : s_last_i;
    assign w_ld_lim  = r_skid_vld ? r_skid_lim  : w_in_lim;

    // The skid only catches a word that arrives while the main word still has beats left.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_vld  <= 1'b0;
            r_skid_word <= '0;
            r_skid_last <= 1'b0;
            r_skid_lim  <= '0;
        end else if (w_wr & ~(w_empty | w_rd_final)) begin
            r_skid_vld  <= 1'b1;
            r_skid_word <= s_data_i;
            r_skid_last <= s_last_i;
            r_skid_lim  <= w_in_lim;
        end else if (w_load) begin
            r_skid_vld  <= 1'b0;
        end
    end
`else
    assign s_ready_o = ~rst & ~r_init & (w_empty | w_rd_final);
    assign w_load    = w_wr;
    assign w_ld_word = s_data_i;
    assign w_ld_last = s_last_i;
    assign w_ld_lim  = w_in_lim;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_lim_nxt   = r_lim;
        w_word_nxt  = r_word;
        w_last_nxt  = r_last;
        if (w_load) begin
            w_state_nxt = BUSY;
            w_idx_nxt   = '0;
            w_lim_nxt   = w_ld_lim;
            w_word_nxt  = w_ld_word;
            w_last_nxt  = w_ld_last;
        end else if (w_rd_final) begin
            w_state_nxt = EMPTY;
        end else if (w_rd) begin
            w_idx_nxt   = r_idx + 1'b1;
        end
    end

    // r_init keeps s_ready_o low for the first cycle after reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_idx   <= '0;
            r_lim   <= '0;
            r_word  <= '0;
            r_last  <= 1'b0;
            r_init  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_lim   <= w_lim_nxt;
            r_word  <= w_word_nxt;
            r_last  <= w_last_nxt;
            r_init  <= 1'b0;
        end
    end

    assign w_sel     = BIG_ENDIAN ? (LIM_MAX - r_idx) : r_idx;
    assign m_valid_o = w_busy;
    assign m_last_o  = w_busy & r_last & w_final;
    assign m_data_o  = rst ? '0 : r_word[int'(w_sel) * DW_OUT +: DW_OUT];

endmodule

// File: tb/tb_stream_downsizer.sv
// Bench for stream_downsizer: little- and big-endian instances share stimulus and are scored against a beat-queue model.
module tb_stream_downsizer;
    localparam int DW = 8;
    localparam int SC = 4;
    localparam int LW = $clog2(SC);
`ifdef STREAM_DOWNSIZER_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
        bit            eow;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, s_last, s_valid, m_ready;
    logic [DW*SC-1:0] s_data;
    logic [LW-1:0]    s_len;
    logic             le_rdy, le_last, le_vld, be_rdy, be_last, be_vld;
    logic [DW-1:0]    le_dat, be_dat;

    stream_downsizer #(.DW_OUT(DW), .SCALE(SC), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst(rst), .s_data_i(s_data), .s_len_i(s_len), .s_last_i(s_last),
        .s_valid_i(s_valid), .s_ready_o(le_rdy), .m_data_o(le_dat), .m_last_o(le_last),
        .m_valid_o(le_vld), .m_ready_i(m_ready));

    stream_downsizer #(.DW_OUT(DW), .SCALE(SC), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst(rst), .s_data_i(s_data), .s_len_i(s_len), .s_last_i(s_last),
        .s_valid_i(s_valid), .s_ready_o(be_rdy), .m_data_o(be_dat), .m_last_o(be_last),
        .m_valid_o(be_vld), .m_ready_i(m_ready));

    beat_t         q_le[$], q_be[$];
    logic [DW-1:0] log_le[$], log_be[$];
    bit            log_last[$];
    int            log_cyc[$];
    int            n_chk = 0, n_err = 0, cyc = 0, acc_cyc = 0, n_acc = 0;
    bit            acc = 1'b0, rst_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected beats of one accepted word, in emission order for each endianness.
    function automatic void push_word(input logic [DW*SC-1:0] w, input bit l, input logic [LW-1:0] n);
        int    lim;
        beat_t b;
        lim = l ? int'(n) : SC - 1;
        if (lim > SC - 1) lim = SC - 1;
        for (int k = 0; k <= lim; k++) begin
            b.last = l && (k == lim);
            b.eow  = (k == lim);
            b.d    = w[k*DW +: DW];
            q_le.push_back(b);
            b.d    = w[(SC-1-k)*DW +: DW];
            q_be.push_back(b);
        end
    endfunction

    task automatic step();
        bit exp_rdy, rd, wr;
        int nw;
        @(negedge clk);
        nw = 0;
        foreach (q_le[i]) if (q_le[i].eow) nw++;
        if (rst || rst_seen)   exp_rdy = 1'b0;
        else if (SKID != 0)    exp_rdy = (nw <= 1);
        else                   exp_rdy = (q_le.size() == 0) || (m_ready && q_le[0].eow);
        chk("le_s_ready", le_rdy, exp_rdy);
        chk("be_s_ready", be_rdy, exp_rdy);
        if (rst) begin
            chk("rst_le_valid", le_vld, 0);
            chk("rst_le_last", le_last, 0);
            chk("rst_le_data", le_dat, 0);
            chk("rst_be_valid", be_vld, 0);
        end else begin
            chk("le_valid", le_vld, q_le.size() != 0);
            chk("be_valid", be_vld, q_be.size() != 0);
            if (q_le.size() != 0) begin
                chk("le_data", le_dat, q_le[0].d);
                chk("le_last", le_last, q_le[0].last);
                chk("be_data", be_dat, q_be[0].d);
                chk("be_last", be_last, q_be[0].last);
            end else begin
                chk("le_last_idle", le_last, 0);
            end
        end
        wr = exp_rdy && s_valid;
        rd = !rst && (q_le.size() != 0) && m_ready;
        if (rd) begin
            log_le.push_back(le_dat);
            log_be.push_back(be_dat);
            log_last.push_back(le_last);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        acc = wr;
        if (wr) begin
            acc_cyc = cyc;
            n_acc++;
        end
        if (rst) begin
            q_le.delete();
            q_be.delete();
        end else begin
            if (rd) begin
                void'(q_le.pop_front());
                void'(q_be.pop_front());
            end
            if (wr) push_word(s_data, s_last, s_len);
        end
        rst_seen = rst;
        cyc++;
        #1;
    endtask

    task automatic send_word(input logic [DW*SC-1:0] w, input bit l, input logic [LW-1:0] n);
        s_data  = w;
        s_last  = l;
        s_len   = n;
        s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (acc) break;
        end
        chk("send_accepted", acc, 1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (q_le.size() == 0 && !s_valid) break;
            step();
            if (acc) s_valid = 1'b0;
        end
        chk("drain_done", q_le.size(), 0);
        step();
    endtask

    task automatic clear_log();
        log_le.delete();
        log_be.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_b[8];
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_len = '0; s_last = 1'b0; m_ready = 1'b1;
        #1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Full word, both slice orders, one beat per cycle from the cycle after acceptance.
        clear_log();
        send_word(32'h44332211, 1'b0, '0);
        drain();
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0, 8'h0, 8'h0, 8'h0};
        chk("t1_count", log_le.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_le_beat", log_le[i], exp_b[i]);
            chk("t1_be_beat", log_be[i], exp_b[3-i]);
            chk("t1_last", log_last[i], 0);
        end
        chk("t1_latency", log_cyc[0], acc_cyc + 1);
        chk("t1_contig", log_cyc[3], log_cyc[0] + 3);

        // Short last word: two beats, last on the second, upper slices dropped.
        clear_log();
        send_word(32'hDDCCBBAA, 1'b1, LW'(1));
        drain();
        chk("t3_count", log_le.size(), 2);
        chk("t3_beat0", log_le[0], 8'hAA);
        chk("t3_beat1", log_le[1], 8'hBB);
        chk("t3_last0", log_last[0], 0);
        chk("t3_last1", log_last[1], 1);
        chk("t3_idle_valid", le_vld, 0);

        // Back-to-back words with no bubble between them.
        clear_log();
        m_ready = 1'b1;
        send_word(32'h04030201, 1'b0, '0);
        send_word(32'h08070605, 1'b0, '0);
        drain();
        chk("t4_count", log_le.size(), 8);
        for (int i = 0; i < 8; i++) chk("t4_beat", log_le[i], i + 1);
        chk("t4_contig", log_cyc[7], log_cyc[0] + 7);

        // Stall on beat 2 while a second word waits at the input.
        clear_log();
        m_ready = 1'b1;
        send_word(32'h44332211, 1'b0, '0);
        s_data = 32'h88776655; s_last = 1'b0; s_valid = 1'b1;
        n_acc = 0;
        repeat (2) begin
            step();
            if (acc) s_valid = 1'b0;
        end
        m_ready = 1'b0;
        repeat (5) begin
            step();
            if (acc) s_valid = 1'b0;
            chk("t5_stall_data", le_dat, 8'h33);
            chk("t5_stall_valid", le_vld, 1);
        end
        chk("t5_accepts", n_acc, SKID);
        drain();
        chk("t5_count", log_le.size(), 8);
        for (int i = 0; i < 8; i++) chk("t5_beat", log_le[i], 32'h11 * (i + 1));

        // Reset pulse mid-word: no leftover beats, one cycle of s_ready low, fresh word from beat 0.
        m_ready = 1'b1;
        send_word(32'h44332211, 1'b0, '0);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_post_rst_valid", le_vld, 0);
        chk("t6_post_rst_ready", le_rdy, 0);
        step();
        clear_log();
        send_word(32'h0D0C0B0A, 1'b0, '0);
        drain();
        chk("t6_count", log_le.size(), 4);
        chk("t6_first", log_le[0], 8'h0A);

        // Random traffic with random backpressure and occasional reset.
        for (int i = 0; i < 600; i++) begin
            if (!s_valid || acc) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = $urandom;
                s_last  = 1'($urandom_range(0, 1));
                s_len   = LW'($urandom_range(0, SC - 1));
            end
            m_ready = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        s_valid = 1'b0;
        step();
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
